// File: rtl/dds_multichannel_avalon.sv
// N-channel phase accumulator with double-buffered tuning, offset and linear sweep,
// programmed through an Avalon-MM slave with per-channel and broadcast commits.
module dds_multichannel_avalon #(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned INC_WIDTH = 32,
   parameter int unsigned PHASE_W   = 14,
   parameter int unsigned DWELL_W   = 16,
   parameter int unsigned ADDR_W    = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      chipselect,
   input  logic                      write,
   input  logic                      read,
   input  logic [ADDR_W-1:0]         address,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   output logic [N_CH*PHASE_W-1:0]   o_phase,
   output logic [N_CH-1:0]           o_valid,
   output logic                      o_irq
);

   localparam int unsigned CH_W = ADDR_W - 3;

   typedef enum logic [1:0] {StIdle, StDwell, StDone} sweep_st_e;

   logic [2:0]      reg_sel;
   logic [CH_W-1:0] ch_sel;
   logic            wr_en, cmd_wr;
   logic [N_CH-1:0] hit, commit, clear;
   logic [31:0]     rd_val;

   logic [4:0]           ctrl_sh [N_CH];
   logic [INC_WIDTH-1:0] inc_sh  [N_CH];
   logic [INC_WIDTH-1:0] ofs_sh  [N_CH];
   logic [INC_WIDTH-1:0] step_sh [N_CH];
   logic [INC_WIDTH-1:0] lim_sh  [N_CH];
   logic [DWELL_W-1:0]   dwell_sh[N_CH];

   logic [4:0]           ctrl_q  [N_CH];
   logic [INC_WIDTH-1:0] start_q [N_CH];
   logic [INC_WIDTH-1:0] ofs_q   [N_CH];
   logic [INC_WIDTH-1:0] step_q  [N_CH];
   logic [INC_WIDTH-1:0] lim_q   [N_CH];
   logic [DWELL_W-1:0]   dwell_q [N_CH];
   logic [INC_WIDTH-1:0] acc_q   [N_CH];
   logic [PHASE_W-1:0]   phase_q [N_CH];

   sweep_st_e            state_q [N_CH];
   sweep_st_e            state_d [N_CH];
   logic [INC_WIDTH-1:0] cur_q   [N_CH];
   logic [INC_WIDTH-1:0] cur_d   [N_CH];
   logic [DWELL_W-1:0]   cnt_q   [N_CH];
   logic [DWELL_W-1:0]   cnt_d   [N_CH];
   logic [N_CH-1:0]      done_q, done_d, over;
   logic [INC_WIDTH:0]   nxt     [N_CH];

   assign reg_sel = address[2:0];
   assign ch_sel  = address[ADDR_W-1:3];
   assign wr_en   = chipselect & write;
   assign cmd_wr  = wr_en & (reg_sel == 3'd7) & (|hit);

   // Out-of-range channel indices match no hit bit, so they neither write nor broadcast.
   always_comb begin
      hit    = '0;
      commit = '0;
      clear  = '0;
      for (int k = 0; k < N_CH; k++) begin
         hit[k]    = (ch_sel == CH_W'(k));
         commit[k] = cmd_wr & (writedata[2] | (hit[k] & writedata[0]));
         clear[k]  = cmd_wr & writedata[1] & (writedata[2] | hit[k]);
      end
   end

   always_comb begin
      rd_val = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (hit[k]) begin
            case (reg_sel)
               3'd0: rd_val = 32'(ctrl_sh[k]);
               3'd1: rd_val = 32'(inc_sh[k]);
               3'd2: rd_val = 32'(ofs_sh[k]);
               3'd3: rd_val = 32'(step_sh[k]);
               3'd4: rd_val = 32'(lim_sh[k]);
               3'd5: rd_val = 32'(dwell_sh[k]);
               3'd6: rd_val = 32'(cur_q[k]);
               3'd7: rd_val = {29'd0, done_q[k], state_q[k] == StDwell, ctrl_q[k][0]};
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         readdata <= '0;
         for (int k = 0; k < N_CH; k++) begin
            ctrl_sh[k]  <= '0;
            inc_sh[k]   <= '0;
            ofs_sh[k]   <= '0;
            step_sh[k]  <= '0;
            lim_sh[k]   <= '0;
            dwell_sh[k] <= '0;
            ctrl_q[k]   <= '0;
            start_q[k]  <= '0;
            ofs_q[k]    <= '0;
            step_q[k]   <= '0;
            lim_q[k]    <= '0;
            dwell_q[k]  <= '0;
            acc_q[k]    <= '0;
            phase_q[k]  <= '0;
         end
      end else begin
         if (chipselect && read) readdata <= rd_val;
         for (int k = 0; k < N_CH; k++) begin
            if (wr_en && hit[k]) begin
               case (reg_sel)
                  3'd0:    ctrl_sh[k]  <= writedata[4:0];
                  3'd1:    inc_sh[k]   <= writedata[INC_WIDTH-1:0];
                  3'd2:    ofs_sh[k]   <= writedata[INC_WIDTH-1:0];
                  3'd3:    step_sh[k]  <= writedata[INC_WIDTH-1:0];
                  3'd4:    lim_sh[k]   <= writedata[INC_WIDTH-1:0];
                  3'd5:    dwell_sh[k] <= writedata[DWELL_W-1:0];
                  default: ;
               endcase
            end
            if (commit[k]) begin
               ctrl_q[k]  <= ctrl_sh[k];
               start_q[k] <= inc_sh[k];
               ofs_q[k]   <= ofs_sh[k];
               step_q[k]  <= step_sh[k];
               lim_q[k]   <= lim_sh[k];
               dwell_q[k] <= dwell_sh[k];
            end
            if (clear[k]) acc_q[k] <= '0;
            else if (ctrl_q[k][0]) acc_q[k] <= acc_q[k] + cur_q[k];
            if (ctrl_q[k][0]) begin
               phase_q[k] <= PHASE_W'((acc_q[k] + ofs_q[k]) >> (INC_WIDTH - PHASE_W));
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         done_q <= '0;
         for (int k = 0; k < N_CH; k++) begin
            state_q[k] <= StIdle;
            cur_q[k]   <= '0;
            cnt_q[k]   <= '0;
         end
      end else begin
         done_q <= done_d;
         for (int k = 0; k < N_CH; k++) begin
            state_q[k] <= state_d[k];
            cur_q[k]   <= cur_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   // Step arithmetic is one bit wider so carry/borrow counts as passing the limit.
   always_comb begin
      done_d = done_q;
      over   = '0;
      for (int k = 0; k < N_CH; k++) begin
         state_d[k] = state_q[k];
         cur_d[k]   = cur_q[k];
         cnt_d[k]   = cnt_q[k];
         nxt[k]     = ctrl_q[k][2] ? ({1'b0, cur_q[k]} - {1'b0, step_q[k]})
                                   : ({1'b0, cur_q[k]} + {1'b0, step_q[k]});
         over[k]    = ctrl_q[k][2] ? (nxt[k][INC_WIDTH] || (nxt[k][INC_WIDTH-1:0] < lim_q[k]))
                                   : (nxt[k] > {1'b0, lim_q[k]});
         if (commit[k]) begin
            state_d[k] = (ctrl_sh[k][0] && ctrl_sh[k][1]) ? StDwell : StIdle;
            cur_d[k]   = inc_sh[k];
            cnt_d[k]   = '0;
            done_d[k]  = 1'b0;
         end else if (ctrl_q[k][0] && ctrl_q[k][1] && state_q[k] == StDwell) begin
            if (cnt_q[k] != dwell_q[k]) begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end else begin
               cnt_d[k] = '0;
               if (step_q[k] != '0) begin
                  if (!over[k]) begin
                     cur_d[k] = nxt[k][INC_WIDTH-1:0];
                  end else begin
                     done_d[k] = 1'b1;
                     if (ctrl_q[k][3]) begin
                        cur_d[k] = start_q[k];
                     end else begin
                        cur_d[k]   = lim_q[k];
                        state_d[k] = StDone;
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      o_phase = '0;
      o_valid = '0;
      o_irq   = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         o_phase[k*PHASE_W +: PHASE_W] = phase_q[k];
         o_valid[k] = ctrl_q[k][0];
         o_irq      = o_irq | (done_q[k] & ctrl_q[k][4]);
      end
   end

endmodule

// File: tb/tb_dds_multichannel_avalon.sv
// Scoreboard bench: stimulus queues expected read data and timed output samples,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dds_multichannel_avalon;

   localparam int unsigned N_CH      = 4;
   localparam int unsigned INC_WIDTH = 32;
   localparam int unsigned PHASE_W   = 14;
   localparam int unsigned DWELL_W   = 16;
   localparam int unsigned ADDR_W    = 6;
   localparam int K_PHASE = 0;
   localparam int K_VALID = 1;
   localparam int K_IRQ   = 2;

   typedef struct {string name; logic [31:0] val;} rd_t;
   typedef struct {int cyc; int kind; int ch; logic [31:0] val;} obs_t;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    chipselect = 1'b0, write = 1'b0, read = 1'b0;
   logic [ADDR_W-1:0]       address = '0;
   logic [31:0]             writedata = '0;
   logic [31:0]             readdata;
   logic [N_CH*PHASE_W-1:0] o_phase;
   logic [N_CH-1:0]         o_valid;
   logic                    o_irq;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic rd_pend = 1'b0;
   rd_t  rd_q[$];
   obs_t obs_q[$];

   dds_multichannel_avalon #(
      .N_CH(N_CH), .INC_WIDTH(INC_WIDTH), .PHASE_W(PHASE_W), .DWELL_W(DWELL_W), .ADDR_W(ADDR_W)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata),
      .o_phase(o_phase), .o_valid(o_valid), .o_irq(o_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_pend <= chipselect & read;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_pend) begin
         if (rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got %h want none", readdata);
         end else begin
            rd_t e;
            e = rd_q.pop_front();
            cmp(e.name, readdata, e.val);
         end
      end
      while (obs_q.size() != 0 && obs_q[0].cyc <= cyc) begin
         obs_t o;
         o = obs_q.pop_front();
         if (o.cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL obs_missed: got cycle %0d want cycle %0d", cyc, o.cyc);
         end else begin
            case (o.kind)
               K_PHASE: cmp($sformatf("phase%0d@%0d", o.ch, o.cyc),
                            32'(o_phase[o.ch*PHASE_W +: PHASE_W]), o.val);
               K_VALID: cmp($sformatf("valid@%0d", o.cyc), 32'(o_valid), o.val);
               default: cmp($sformatf("irq@%0d", o.cyc), 32'(o_irq), o.val);
            endcase
         end
      end
   end

   function automatic logic [ADDR_W-1:0] mk_addr(input int ch, input int r);
      return {ch[2:0], r[2:0]};
   endfunction

   task automatic push_obs(input int dc, input int kind, input int ch, input logic [31:0] val);
      obs_q.push_back('{cyc + dc, kind, ch, val});
   endtask

   task automatic bus_write(input int ch, input int r, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; read = 1'b0;
      address = mk_addr(ch, r); writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input int ch, input int r, input logic [31:0] exp, input string name);
      rd_q.push_back('{name, exp});
      chipselect = 1'b1; read = 1'b1; write = 1'b0;
      address = mk_addr(ch, r);
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic bus_rw(input int ch, input int r, input logic [31:0] d, input logic [31:0] exp);
      rd_q.push_back('{"rw_pre_write", exp});
      chipselect = 1'b1; read = 1'b1; write = 1'b1;
      address = mk_addr(ch, r); writedata = d;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) push_obs(1, K_PHASE, k, 0);
      push_obs(1, K_VALID, 0, 0);
      push_obs(1, K_IRQ, 0, 0);
      for (int r = 0; r < 8; r++) bus_read(0, r, 0, $sformatf("rst_ch0_r%0d", r));
      for (int r = 0; r < 8; r++) bus_read(3, r, 0, $sformatf("rst_ch3_r%0d", r));

      // ch1 free-running at a quarter turn per cycle
      bus_write(1, 1, 32'h4000_0000);
      bus_write(1, 0, 32'h1);
      push_obs(2, K_VALID, 0, 32'h2);
      push_obs(3, K_PHASE, 0, 0);
      push_obs(3, K_PHASE, 2, 0);
      push_obs(3, K_PHASE, 1, 32'h1000);
      push_obs(4, K_PHASE, 1, 32'h2000);
      push_obs(5, K_PHASE, 1, 32'h3000);
      push_obs(6, K_PHASE, 1, 32'h0000);
      bus_write(1, 7, 32'h1);
      bus_read(1, 7, 32'h1, "ch1_status");
      bus_read(1, 0, 32'h1, "ch1_ctrl");
      repeat (6) @(negedge clk);

      // ch0 up sweep, single shot
      bus_write(0, 1, 100);
      bus_write(0, 3, 10);
      bus_write(0, 4, 125);
      bus_write(0, 5, 3);
      bus_write(0, 0, 32'h13);
      push_obs(12, K_IRQ, 0, 0);
      push_obs(13, K_IRQ, 0, 1);
      bus_write(0, 7, 32'h1);
      for (int i = 0; i < 16; i++)
         bus_read(0, 6, (i < 12) ? 32'(100 + 10 * (i / 4)) : 32'd125, $sformatf("up_cur%0d", i));
      bus_read(0, 7, 32'h5, "up_status");

      // ch0 up sweep with auto reload
      bus_write(0, 0, 32'h1B);
      push_obs(2, K_IRQ, 0, 0);
      push_obs(13, K_IRQ, 0, 1);
      bus_write(0, 7, 32'h1);
      for (int i = 0; i < 16; i++)
         bus_read(0, 6, (i / 4 == 3) ? 32'd100 : 32'(100 + 10 * (i / 4)),
                  $sformatf("reload_cur%0d", i));
      bus_read(0, 7, 32'h7, "reload_status");

      // ch2 down sweep that borrows past zero
      bus_write(2, 1, 8);
      bus_write(2, 3, 10);
      bus_write(2, 4, 5);
      bus_write(2, 5, 0);
      bus_write(2, 0, 32'h7);
      bus_write(2, 7, 32'h1);
      bus_read(2, 6, 8, "down_cur0");
      bus_read(2, 6, 5, "down_cur1");
      bus_read(2, 6, 5, "down_cur2");
      bus_read(2, 7, 32'h5, "down_status");

      // coherent commit-all with accumulator clear
      for (int k = 0; k < 4; k++) begin
         bus_write(k, 1, 32'(k + 1));
         bus_write(k, 0, 32'h1);
      end
      bus_write(0, 2, 32'h1000_0000);
      bus_write(1, 2, 32'h2004_0000);
      bus_write(2, 2, 32'hABC0_0000);
      bus_write(3, 2, 32'hFFFC_0000);
      push_obs(2, K_VALID, 0, 32'hF);
      for (int d = 2; d < 4; d++) begin
         push_obs(d, K_PHASE, 0, 32'h0400);
         push_obs(d, K_PHASE, 1, 32'h0801);
         push_obs(d, K_PHASE, 2, 32'h2AF0);
         push_obs(d, K_PHASE, 3, 32'h3FFF);
      end
      bus_write(0, 7, 32'h6);
      repeat (3) @(negedge clk);

      // channel index out of range
      bus_write(2, 1, 32'h999);
      bus_write(4, 1, 32'hDEAD_BEEF);
      bus_write(4, 7, 32'h7);
      bus_read(4, 1, 0, "bad_ch_inc");
      bus_read(4, 6, 0, "bad_ch_cur");
      bus_read(0, 1, 1, "ch0_inc_kept");
      bus_read(2, 6, 3, "ch2_cur_kept");

      // simultaneous read and write returns the old value
      bus_rw(2, 2, 32'h1111_0000, 32'hABC0_0000);
      bus_read(2, 2, 32'h1111_0000, "rw_post_write");

      // reset in the middle of a finished sweep drops irq at once
      bus_write(0, 1, 120);
      bus_write(0, 0, 32'h13);
      push_obs(4, K_IRQ, 0, 0);
      push_obs(5, K_IRQ, 0, 1);
      push_obs(7, K_IRQ, 0, 1);
      bus_write(0, 7, 32'h1);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      cmp("rst_async_irq", 32'(o_irq), 0);
      cmp("rst_async_valid", 32'(o_valid), 0);
      cmp("rst_async_phase", 32'(|o_phase), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(0, 6, 0, "post_rst_cur");
      bus_read(0, 7, 0, "post_rst_status");
      bus_read(0, 0, 0, "post_rst_ctrl");
      bus_read(2, 2, 0, "post_rst_ofs");
      repeat (3) @(negedge clk);

      cmp("rd_q_drained", 32'(rd_q.size()), 0);
      cmp("obs_q_drained", 32'(obs_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dds_multichannel_avalon.md
# dds_multichannel_avalon

Parametrised N-channel phase-generator core behind an Avalon-MM slave, the successor to the single-channel button-driven DDS slave. Each channel has double-buffered tuning, phase-offset and linear-sweep registers. Commits can target one channel or all channels at once, so phases stay coherent. Per-channel phase words feed the downstream sine/cosine LUT and DAC stage, and a sweep-done interrupt goes to the host.

## Interface
- N_CH, 4: channel count, 1..16.
- INC_WIDTH, 32: tuning word / accumulator width, 8..32.
- PHASE_W, 14: output phase width, ≤ INC_WIDTH.
- DWELL_W, 16: sweep dwell counter width.
- ADDR_W, 5: Avalon word address width; must be ≥ 3+clog2(N_CH).
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- chipselect, write, read  in  1 each  Avalon-MM strobes.
- address  in  ADDR_W  word address; reg = address[2:0], ch = address[ADDR_W-1:3].
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- o_phase  out  N_CH*PHASE_W  channel k in bits [k*PHASE_W +: PHASE_W].
- o_valid  out  N_CH  channel active-enabled.
- o_irq  out  1  OR over channels of (sweep_done & irq_en).

## Operation
- Per-channel register map, reg index: write-only shadows unless noted; unused writedata bits are ignored and read as 0.
  - 0 CTRL: b0 enable, b1 sweep_en, b2 dir (0 up, 1 down), b3 auto_reload, b4 irq_en.
  - 1 INC_START.
  - 2 PHASE_OFS.
  - 3 SWEEP_STEP.
  - 4 SWEEP_LIMIT.
  - 5 DWELL.
  - 6 CUR_INC, read-only active increment.
  - 7 CMD/STATUS.
    - Write: b0 commit this channel, b1 clear accumulator, b2 commit all channels.
    - Read: b0 active enable, b1 sweeping, b2 sweep_done (sticky).
- Registers 0–5 read back their shadow values.
- Channel index ≥ N_CH: writes are ignored, reads return 0.
- Commit copies shadows to active and loads cur_inc ← INC_START. It also resets the dwell counter and clears sweep_done.
  - b2 commits every channel in the same cycle; b0 is redundant when b2 is set.
  - b1 without a commit zeroes only the accumulator. b1 with b2 zeroes all accumulators.
- Accumulator: acc ← (acc + cur_inc) mod 2^INC_WIDTH each cycle while active enable = 1. acc holds while disabled.
- Phase: o_phase ← top PHASE_W bits of (acc + active PHASE_OFS) mod 2^INC_WIDTH, registered.
- Sweep state machine per channel, with states IDLE, DWELL, DONE:
  - IDLE → DWELL when enable & sweep_en are active after a commit.
  - DWELL: count DWELL+1 cycles. On expiry, next = cur_inc ± SWEEP_STEP, computed on INC_WIDTH+1 bits (no wrap).
  - Up: if next > LIMIT, or carry out of the INC_WIDTH-bit sum. Down: if next < LIMIT, or borrow.
    - auto_reload=0: cur_inc ← LIMIT, set done, → DONE.
    - auto_reload=1: cur_inc ← INC_START, set done, stay in DWELL.
  - Otherwise cur_inc ← next and the count restarts.
  - DONE holds cur_inc until the next commit.
  - SWEEP_STEP = 0: cur_inc is constant and done never sets.
- Disabling a channel (commit with enable=0) freezes acc, o_phase and the sweep state; o_valid=0.

## Timing
- Reset (i_rst_n=0, asynchronous) clears:
  - all shadow and active registers, acc and the dwell counters;
  - readdata=0, o_phase=0, o_valid=0, o_irq=0;
  - every sweep FSM, which returns to IDLE.
- Read latency is 1 cycle: readdata is valid on the edge after chipselect&read and holds until the next read. Writes have no wait states.
- Commit written at edge T: active values apply from edge T+1, so the first acc update uses the new cur_inc at T+1.
  - o_phase reflects the committed offset and acc at T+2.
  - o_valid changes at T+1.
- Sweep step visible in CUR_INC exactly DWELL+1 cycles after the previous step or after commit.
- o_irq is combinational from the registered done/irq_en bits, so it rises the cycle after done sets.
- Asserting reset mid-sweep aborts it immediately; there is no partial state after release.
- chipselect, read and write together: the write takes effect and readdata shows the pre-write value.

## Test plan
- Reset, then read every register of ch0 and ch3 → all 0. Outputs all 0.
- ch1: INC_START=0x4000_0000, CTRL=1, commit.
  - o_phase ch1 (PHASE_W=14) steps 0x1000, 0x2000, 0x3000, 0x0000 from T+2; o_valid[1]=1 at T+1.
  - Other channels stay 0.
- ch0 sweep up: INC_START=100, STEP=10, LIMIT=125, DWELL=3, CTRL=0x13, commit.
  - CUR_INC reads 100 → 110 (4 cycles later) → 120 → 125, then done=1 and o_irq=1.
  - Repeat with CTRL=0x1B (auto_reload): CUR_INC 120 → 100, and done stays sticky.
- Down sweep with LIMIT=5, INC_START=8, STEP=10 → borrow detected; CUR_INC=5 and done set, with no wrap to a large value.
- Channels 0–3 set with different INC/OFS, then a commit-all with clear (b2|b1) → all o_phase equal their offsets' top bits on the same cycle.
- Write and read at address ch=N_CH → no state change and readdata=0. Reset asserted mid-sweep → o_irq drops asynchronously.
